// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_if : hazard-controller bus (decode/execute status in, pipeline enables out).
// Rev 1.0 : initial release. Optional macro HAZARD_STATS_EN adds statistics outputs.
// ============================================================================
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_uses_rt_i;
    logic       ie_memread_i;
    logic [4:0] ie_rt_i;
    logic       ex_redirect_i;
    logic       mem_busy_i;
    logic       pc_en_o;
    logic       if_id_en_o;
    logic       if_id_flush_o;
    logic       id_ex_flush_o;
    logic       stall_o;
    logic [1:0] state_o;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ie_memread_i, ie_rt_i, ex_redirect_i, mem_busy_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, stall_o, state_o,
        input  stall_cnt_o, flush_cnt_o
    );
    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ie_memread_i, ie_rt_i, ex_redirect_i, mem_busy_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, stall_o, state_o,
        output stall_cnt_o, flush_cnt_o
    );
`else
    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ie_memread_i, ie_rt_i, ex_redirect_i, mem_busy_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, stall_o, state_o
    );
    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ie_memread_i, ie_rt_i, ex_redirect_i, mem_busy_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, stall_o, state_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : load-use stall, redirect flush and memory-wait freeze control.
// Rev 1.0 : initial release. Optional macro HAZARD_STATS_EN adds hazard statistics.
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } state_e;

    localparam logic [2:0] c_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    state_e     saved_q, saved_d;
    logic [2:0] cnt_q, cnt_d;
    state_e     w_eff;
    logic       w_hazard;
    logic       w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_flush, w_stall;

    assign w_hazard = bus.ie_memread_i && (bus.ie_rt_i != 5'd0) &&
                      ((bus.ie_rt_i == bus.id_rs_i) ||
                       (bus.id_uses_rt_i && (bus.ie_rt_i == bus.id_rt_i)));

    // Leaving MEMWAIT resumes the saved state in the same cycle, so no extra dead cycle appears.
    assign w_eff = (state_q == MEMWAIT) ? saved_q : state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        saved_d       = saved_q;
        cnt_d         = cnt_q;
        w_pc_en       = 1'b0;
        w_if_id_en    = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_stall       = 1'b0;
        if (bus.mem_busy_i) begin
            state_d = MEMWAIT;
            saved_d = w_eff;
        end else begin
            case (w_eff)
                RUN: begin
                    if (bus.ex_redirect_i) begin
                        w_pc_en       = 1'b1;
                        w_if_id_en    = 1'b1;
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                        cnt_d         = c_FLUSH_RELOAD;
                        state_d       = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end else if (w_hazard) begin
                        w_stall = 1'b1;
                        state_d = LDSTALL;
                    end else begin
                        w_pc_en    = 1'b1;
                        w_if_id_en = 1'b1;
                        state_d    = RUN;
                    end
                end
                FLUSH: begin
                    w_pc_en       = 1'b1;
                    w_if_id_en    = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    if (bus.ex_redirect_i) begin
                        cnt_d   = c_FLUSH_RELOAD;
                        state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end else if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = RUN;
                    end else begin
                        cnt_d   = cnt_q - 3'd1;
                        state_d = FLUSH;
                    end
                end
                default: begin
                    w_pc_en    = 1'b1;
                    w_if_id_en = 1'b1;
                    state_d    = RUN;
                end
            endcase
        end
    end

    // Enables are forced low while reset is asserted.
    assign bus.pc_en_o       = rst_n & w_pc_en;
    assign bus.if_id_en_o    = rst_n & w_if_id_en;
    assign bus.if_id_flush_o = rst_n & w_if_id_flush;
    assign bus.id_ex_flush_o = rst_n & w_id_ex_flush;
    assign bus.stall_o       = rst_n & w_stall;
    assign bus.state_o       = state_q;

`ifdef HAZARD_STATS_EN
    logic        w_stall_evt, w_flush_evt;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    assign w_stall_evt = !bus.mem_busy_i && (w_eff == RUN) && !bus.ex_redirect_i && w_hazard;
    assign w_flush_evt = !bus.mem_busy_i && ((w_eff == RUN) || (w_eff == FLUSH)) && bus.ex_redirect_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (w_stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (w_flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Self-checking bench for pipe_hazard_ctrl: directed steps, expected outputs queued then compared.
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic [1:0] st;
        logic       pc;
        logic       ifid;
        logic       fl1;
        logic       fl2;
        logic       stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    exp_t sb[$];

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        e = sb.pop_front();
        cmp({tag, ".state"},       16'(bus.state_o),       16'(e.st));
        cmp({tag, ".pc_en"},       16'(bus.pc_en_o),       16'(e.pc));
        cmp({tag, ".if_id_en"},    16'(bus.if_id_en_o),    16'(e.ifid));
        cmp({tag, ".if_id_flush"}, 16'(bus.if_id_flush_o), 16'(e.fl1));
        cmp({tag, ".id_ex_flush"}, 16'(bus.id_ex_flush_o), 16'(e.fl2));
        cmp({tag, ".stall"},       16'(bus.stall_o),       16'(e.stl));
    endtask

    // One clock with the currently driven inputs; outputs sampled mid-cycle.
    task automatic step(input string tag, input logic [1:0] st, input logic pc, input logic ifid,
                        input logic fl1, input logic fl2, input logic stl);
        sb.push_back('{st, pc, ifid, fl1, fl2, stl});
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0; bus.id_uses_rt_i = 1'b0;
        bus.ie_memread_i = 1'b0; bus.ie_rt_i = 5'd0;
        bus.ex_redirect_i = 1'b0; bus.mem_busy_i = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef HAZARD_STATS_EN
        cmp({tag, ".stall_cnt"}, bus.stall_cnt_o, 16'(m_stall));
        cmp({tag, ".flush_cnt"}, bus.flush_cnt_o, 16'(m_flush));
`else
        if (m_stall < 0 || m_flush < 0) $display("model underflow %s", tag);
`endif
    endtask

    initial begin
        idle_inputs();
        step("reset", 2'd0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step("run_idle", 2'd0, 1, 1, 0, 0, 0);

        // Load-use on rs
        bus.ie_memread_i = 1'b1; bus.ie_rt_i = 5'd5; bus.id_rs_i = 5'd5;
        step("lu_rs", 2'd0, 0, 0, 0, 0, 1); m_stall++;
        step("lu_bubble", 2'd1, 1, 1, 0, 0, 0);
        idle_inputs();
        step("lu_back", 2'd0, 1, 1, 0, 0, 0);

        // Register zero is never a hazard
        bus.ie_memread_i = 1'b1; bus.ie_rt_i = 5'd0; bus.id_rs_i = 5'd0;
        step("r0_exempt", 2'd0, 1, 1, 0, 0, 0);

        // rt match only counts when decode actually reads rt
        bus.ie_rt_i = 5'd7; bus.id_rs_i = 5'd3; bus.id_rt_i = 5'd7; bus.id_uses_rt_i = 1'b0;
        step("rt_unused", 2'd0, 1, 1, 0, 0, 0);
        bus.id_uses_rt_i = 1'b1;
        step("rt_used", 2'd0, 0, 0, 0, 0, 1); m_stall++;
        idle_inputs();
        step("rt_bubble", 2'd1, 1, 1, 0, 0, 0);

        // Redirect pulse: two flush cycles
        bus.ex_redirect_i = 1'b1;
        step("redir", 2'd0, 1, 1, 1, 1, 0); m_flush++;
        bus.ex_redirect_i = 1'b0;
        step("flush1", 2'd2, 1, 1, 1, 1, 0);
        step("flush_done", 2'd0, 1, 1, 0, 0, 0);

        // Memory busy arriving in FLUSH with count 1
        bus.ex_redirect_i = 1'b1;
        step("redir2", 2'd0, 1, 1, 1, 1, 0); m_flush++;
        bus.ex_redirect_i = 1'b0; bus.mem_busy_i = 1'b1;
        step("busy_f1", 2'd2, 0, 0, 0, 0, 0);
        step("busy_f2", 2'd3, 0, 0, 0, 0, 0);
        step("busy_f3", 2'd3, 0, 0, 0, 0, 0);
        bus.mem_busy_i = 1'b0;
        step("resume_flush", 2'd3, 1, 1, 1, 1, 0);
        step("resume_run", 2'd0, 1, 1, 0, 0, 0);

        // Redirect and load-use together: flush wins
        bus.ex_redirect_i = 1'b1; bus.ie_memread_i = 1'b1; bus.ie_rt_i = 5'd9; bus.id_rs_i = 5'd9;
        step("redir_vs_lu", 2'd0, 1, 1, 1, 1, 0); m_flush++;
        idle_inputs();
        step("rvl_flush", 2'd2, 1, 1, 1, 1, 0);
        check_stats("rvl");
        step("rvl_run", 2'd0, 1, 1, 0, 0, 0);

        // Redirect inside FLUSH reloads the count
        bus.ex_redirect_i = 1'b1;
        step("reload_a", 2'd0, 1, 1, 1, 1, 0); m_flush++;
        step("reload_b", 2'd2, 1, 1, 1, 1, 0); m_flush++;
        bus.ex_redirect_i = 1'b0;
        step("reload_c", 2'd2, 1, 1, 1, 1, 0);
        step("reload_end", 2'd0, 1, 1, 0, 0, 0);

        // Busy beats a hazard; hazard is honoured on resume
        bus.mem_busy_i = 1'b1; bus.ie_memread_i = 1'b1; bus.ie_rt_i = 5'd4; bus.id_rs_i = 5'd4;
        step("busy_vs_lu", 2'd0, 0, 0, 0, 0, 0);
        bus.mem_busy_i = 1'b0;
        step("resume_lu", 2'd3, 0, 0, 0, 0, 1); m_stall++;
        idle_inputs();
        step("resume_bubble", 2'd1, 1, 1, 0, 0, 0);
        check_stats("pre_reset");

        // Reset during MEMWAIT
        bus.mem_busy_i = 1'b1;
        step("mw_enter", 2'd0, 0, 0, 0, 0, 0);
        step("mw_hold", 2'd3, 0, 0, 0, 0, 0);
        rst_n = 1'b0; m_stall = 0; m_flush = 0;
        #1;
        sb.push_back('{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check_now("mw_async_rst");
        check_stats("rst_stats");
        bus.mem_busy_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("mw_after_rst", 2'd0, 1, 1, 0, 0, 0);

        // Reset during FLUSH abandons the sequence
        bus.ex_redirect_i = 1'b1;
        step("fr_redir", 2'd0, 1, 1, 1, 1, 0);
        bus.ex_redirect_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("fr_after_rst", 2'd0, 1, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
